// File: rtl/sampler_poly.sv
// Polyphonic one-shot sample player: up to 4 voices share one registered ROM port, serviced in turn per strobe.
// Define SAMPLER_POLY_LOOP_EN to loop a voice while its trigger stays high.
module sampler_poly #(
    parameter int W            = 16,
    parameter int FP_OFFSET    = 2,
    parameter int N_VOICES     = 4,
    parameter int N_SAMPLES    = 12'h690,
    parameter     PATH_SAMPLES = "sampler_data/clap.hex",
    parameter int FRAC_W       = 4,
    parameter int RATE         = 8,
    parameter int TRIG_HI_MV   = 1000,
    parameter int TRIG_LO_MV   = 500
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_strobe,
    input  logic [W-1:0] sample_in0,
    input  logic [W-1:0] sample_in1,
    input  logic [W-1:0] sample_in2,
    input  logic [W-1:0] sample_in3,
    output logic [W-1:0] sample_out0,
    output logic [W-1:0] sample_out1,
    output logic [W-1:0] sample_out2,
    output logic [W-1:0] sample_out3,
    input  logic [7:0]   jack,
    output logic         overrun
);
    localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int PW = $clog2(N_SAMPLES) + 1 + FRAC_W;
    localparam int AW = PW - FRAC_W;
    localparam logic signed [W-1:0] TH_HI = W'(TRIG_HI_MV <<< FP_OFFSET);
    localparam logic signed [W-1:0] TH_LO = W'(TRIG_LO_MV <<< FP_OFFSET);
    localparam logic [PW-1:0] END_PH = PW'(N_SAMPLES) << FRAC_W;
    localparam logic [AW-1:0] N_ADDR = AW'(N_SAMPLES);

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_ADDR, SEQ_DATA, SEQ_COMMIT} seq_t;
    typedef enum logic {V_IDLE, V_PLAY} voice_t;

    logic [W-1:0] rom [N_SAMPLES];

    seq_t          seq;
    logic [1:0]    vsel;
    voice_t        vstate [4];
    logic [3:0]    schmitt, sch_nxt;
    logic [PW-1:0] phase [4];
    logic [W-1:0]  stage [4];
    logic [W-1:0]  outq  [4];
    logic [W-1:0]  cv    [4];
    logic [W-1:0]  rom_q;
    logic          rd_ok;
    logic [AW-1:0] cur_addr;
    logic          cur_in;
    logic [PW-1:0] nxt_phase;
    logic          unused_jack;

    assign cv[0] = sample_in0;
    assign cv[1] = sample_in1;
    assign cv[2] = sample_in2;
    assign cv[3] = sample_in3;
    assign unused_jack = ^jack[7:4];

    // Hysteresis: between the thresholds the previous state is held.
    always_comb begin
        for (int v = 0; v < 4; v++) begin
            sch_nxt[v] = schmitt[v];
            if (v >= N_VOICES || !jack[v])         sch_nxt[v] = 1'b0;
            else if ($signed(cv[v]) >= TH_HI)      sch_nxt[v] = 1'b1;
            else if ($signed(cv[v]) < TH_LO)       sch_nxt[v] = 1'b0;
        end
    end

    always_comb begin
        cur_addr  = phase[vsel][PW-1:FRAC_W];
        cur_in    = cur_addr < N_ADDR;
        nxt_phase = phase[vsel] + PW'(RATE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq     <= SEQ_IDLE;
            vsel    <= '0;
            schmitt <= '0;
            rom_q   <= '0;
            rd_ok   <= 1'b0;
            overrun <= 1'b0;
            for (int v = 0; v < 4; v++) begin
                vstate[v] <= V_IDLE;
                phase[v]  <= '0;
                stage[v]  <= '0;
                outq[v]   <= '0;
            end
        end else begin
            if (sample_strobe && seq != SEQ_IDLE) overrun <= 1'b1;
            case (seq)
                SEQ_IDLE: if (sample_strobe) begin
                    schmitt <= sch_nxt;
                    for (int v = 0; v < 4; v++) begin
                        if (sch_nxt[v] && !schmitt[v]) begin
                            vstate[v] <= V_PLAY;
                            phase[v]  <= '0;
                        end
                    end
                    vsel <= '0;
                    seq  <= SEQ_ADDR;
                end
                SEQ_ADDR: begin
                    rd_ok <= (vstate[vsel] == V_PLAY) && cur_in;
                    rom_q <= cur_in ? rom[IW'(cur_addr)] : '0;
                    seq   <= SEQ_DATA;
                end
                SEQ_DATA: begin
                    stage[vsel] <= rd_ok ? rom_q : '0;
                    // Phase advances after this strobe's read; an out-of-range read ends the voice.
                    if (vstate[vsel] == V_PLAY) begin
                        if (!rd_ok)
                            vstate[vsel] <= V_IDLE;
`ifdef SAMPLER_POLY_LOOP_EN
                        else if (nxt_phase >= END_PH && schmitt[vsel])
                            phase[vsel] <= nxt_phase - END_PH;
`endif
                        else
                            phase[vsel] <= nxt_phase;
                    end
                    if (vsel == 2'(N_VOICES - 1)) begin
                        seq <= SEQ_COMMIT;
                    end else begin
                        vsel <= vsel + 2'd1;
                        seq  <= SEQ_ADDR;
                    end
                end
                SEQ_COMMIT: begin
                    for (int v = 0; v < 4; v++) outq[v] <= stage[v];
                    seq <= SEQ_IDLE;
                end
                default: seq <= SEQ_IDLE;
            endcase
        end
    end

    assign sample_out0 = (N_VOICES > 0) ? outq[0] : '0;
    assign sample_out1 = (N_VOICES > 1) ? outq[1] : '0;
    assign sample_out2 = (N_VOICES > 2) ? outq[2] : '0;
    assign sample_out3 = (N_VOICES > 3) ? outq[3] : '0;
endmodule

// File: tb/tb_sampler_poly.sv
// Scoreboard bench for sampler_poly: stimulus queues expected outputs per accepted strobe, a monitor checks each COMMIT.
module tb_sampler_poly;
    localparam int W  = 16;
    localparam int NV = 4;
    localparam int NS = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_strobe = 1'b0;
    logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [W-1:0] out0, out1, out2, out3;
    logic [7:0] jack = 8'hFF;
    logic overrun;
    logic [3:0][W-1:0] outs;
    logic [3:0][W-1:0] expq [$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    assign outs = {out3, out2, out1, out0};

    sampler_poly #(.W(W), .N_VOICES(NV), .N_SAMPLES(NS)) dut (
        .clk(clk), .rst(rst), .sample_strobe(sample_strobe),
        .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
        .sample_out0(out0), .sample_out1(out1), .sample_out2(out2), .sample_out3(out3),
        .jack(jack), .overrun(overrun)
    );

    function automatic logic [W-1:0] rv(input int i);
        return W'(32'h8011 + i * 613);
    endfunction

    function automatic logic [W-1:0] ev(input int i);
        return (i < 0) ? '0 : rv(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobe_push(input logic [W-1:0] e3, input logic [W-1:0] e2,
                               input logic [W-1:0] e1, input logic [W-1:0] e0);
        @(negedge clk);
        sample_strobe = 1'b1;
        expq.push_back({e3, e2, e1, e0});
        @(negedge clk);
        sample_strobe = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Strobes 3 clk apart; only those the sequencer can accept carry an expectation.
    task automatic strobe_fast(input bit accepted, input logic [W-1:0] e0);
        @(negedge clk);
        sample_strobe = 1'b1;
        if (accepted) expq.push_back({{3{W'(0)}}, e0});
        @(negedge clk);
        sample_strobe = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0][W-1:0] prev, exp, act;
        prev = '0;
        forever begin
            @(posedge clk);
            if (rst) prev = '0;
            else if (sample_strobe) begin
                repeat (2*NV) @(posedge clk);
                #1;
                chk("hold_before_commit", outs, prev);
                @(posedge clk);
                #1;
                act = outs;
                if (expq.size() == 0) begin
                    chk("scoreboard_underflow", 64'(expq.size()), 64'd1);
                end else begin
                    exp = expq.pop_front();
                    for (int v = 0; v < 4; v++) chk($sformatf("out%0d", v), act[v], exp[v]);
                    prev = exp;
                end
            end
        end
    end

    initial begin
        int t3_in [12] = '{1000, 4000, 4000, 3000, 3000, 1000, 4000, 4000, 2000, 4000, 1999, 4000};
        int t3_ix [12] = '{-1, 0, 0, 1, 1, 2, 0, 0, 1, 1, 2, 0};
        #1;
        for (int i = 0; i < NS; i++) dut.rom[i] = rv(i);
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, '0);
        chk("reset_overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // one-shot playback at half speed, then silence at 2*NS strobes
        in0 = 16'd4000;
        for (int k = 0; k < 2*NS + 2; k++)
            strobe_push('0, '0, '0, (k < 2*NS) ? rv(k/2) : '0);

        // hysteresis and retrigger
        for (int k = 0; k < 12; k++) begin
            in0 = W'(t3_in[k]);
            strobe_push('0, '0, '0, ev(t3_ix[k]));
        end

        // voice 2 starts 10 strobes after voice 0; voice 1 unplugged with a high CV
        in0 = '0;
        in1 = 16'd5000;
        jack = 8'hFD;
        for (int j = 1; j <= 51; j++) begin
            if (j == 10) in2 = 16'd4000;
            strobe_push('0, (j >= 10 && j - 10 < 2*NS) ? rv((j-10)/2) : '0,
                        '0, (j < 2*NS) ? rv(j/2) : '0);
        end

        // overrun: strobes every 3 clk, every 4th is accepted
        chk("overrun_clear", overrun, 1'b0);
        in0 = 16'd4000;
        for (int s = 0; s < 13; s++)
            strobe_fast(s % 4 == 0, rv((s/4)/2));
        repeat (12) @(negedge clk);
        chk("overrun_sticky", overrun, 1'b1);

        // async reset mid-playback
        @(negedge clk);
        rst = 1'b1;
        in0 = '0;
        in2 = '0;
        #1;
        chk("rst_out0", out0, '0);
        chk("rst_overrun", overrun, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        strobe_push('0, '0, '0, '0);
        strobe_push('0, '0, '0, '0);

        // held trigger: loops when enabled, otherwise a plain one-shot
        in0 = 16'd4000;
        for (int k = 0; k < 46; k++) begin
`ifdef SAMPLER_POLY_LOOP_EN
            strobe_push('0, '0, '0, rv((k/2) % NS));
`else
            strobe_push('0, '0, '0, (k < 2*NS) ? rv(k/2) : '0);
`endif
        end

        repeat (20) @(negedge clk);
        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
